// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the mac_acc_8 stage.
package mac_pkg;

    localparam int         ACC_W_DEF = 24;
    localparam logic [7:0] CNT_MAX   = 8'd255;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

endpackage

// File: rtl/mac_acc_8_multi.sv
// Combinational 8x8 unsigned array multiplier (partial-product rows).
module multi_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] o
);

    always_comb begin
        o = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                o = o + ({8'd0, a} << i);
            end
        end
    end

endmodule

// File: rtl/mac_acc_8.sv
// Streaming 8-bit multiply-accumulate stage with held result port.
// Optional build macro MAC_SAT_EN: clamp the accumulator on overflow.
module mac_acc_8
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    logic             s1_valid_q;
    logic             s1_last_q;
    logic [7:0]       s1_a_q;
    logic [7:0]       s1_b_q;
    logic [15:0]      prod;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_w;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [7:0]       out_count_q;
    logic             out_ovf_q;

    logic             drain;
    logic             accept;

    // Only a last term can stall, and only behind an unconsumed result.
    assign drain    = s1_valid_q &&
                      !(s1_last_q && out_valid_q && !out_ready);
    assign in_ready = !s1_valid_q || drain;
    assign accept   = in_valid && in_ready;

    multi_8 u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .o (prod)
    );

    always_comb begin
        base  = (state_q == IDLE) ? '0 : acc_q;
        sum_w = {1'b0, base} + {{(ACC_W - 15){1'b0}}, prod};
        ovf_d = ((state_q == ACCUM) && ovf_q) || sum_w[ACC_W];
`ifdef MAC_SAT_EN
        acc_d = ovf_d ? '1 : sum_w[ACC_W-1:0];
`else
        acc_d = sum_w[ACC_W-1:0];
`endif
        if (state_q == IDLE) begin
            cnt_d = 8'd1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_last_q  <= in_last;
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
        end else if (drain) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (drain) begin
                if (s1_last_q) begin
                    out_valid_q <= 1'b1;
                    out_sum_q   <= acc_d;
                    out_count_q <= cnt_d;
                    out_ovf_q   <= ovf_d;
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    state_q <= ACCUM;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/mac_acc_8.md
# mac_acc_8

Streaming 8-bit multiply-accumulate stage that sits directly upstream of the accumulation/readout logic and wraps the existing combinational 8-bit array multiplier `multi_8`. It accepts a stream of unsigned operand pairs over a valid/ready handshake and registers each pair. It sums the 16-bit products over a vector delimited by `in_last`, then presents the dot-product result on a held valid/ready output port.

## Interface
- `ACC_W`, 24: accumulator and result width in bits, minimum 16. With 24 bits, 256 full-scale terms (255×255) fit without overflow.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: an operand pair is present.
- `in_ready` output 1: the stage can accept a pair this cycle.
- `in_a` input 8: unsigned multiplicand.
- `in_b` input 8: unsigned multiplier.
- `in_last` input 1: this pair is the final term of the vector.
- `out_valid` output 1: a result is held on the output.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output ACC_W: accumulated sum of products.
- `out_count` output 8: number of terms in the vector, saturating at 255.
- `out_ovf` output 1: the accumulator overflowed during this vector.

## Operation
- **Stage 1 (operand register)**
  - A pair is accepted when `in_valid && in_ready`.
  - The accepted pair is captured into `s1_a`, `s1_b` and `s1_last`, and `s1_valid` is set.
  - `multi_8` computes the product combinationally from `s1_a` and `s1_b`.
- **Stage 2 (accumulate)**
  - The FSM has two states:
    - `IDLE`: no partial sum is held.
    - `ACCUM`: at least one term is held.
  - When stage 1 drains, the term is added:
    - In `IDLE`: `acc = product`, `cnt = 1`.
    - In `ACCUM`: `acc = acc + product`, `cnt = sat255(cnt + 1)`.
    - A carry out of ACC_W bits sets the sticky `ovf` flag.
  - State transitions:
    - A non-last term moves the FSM to `ACCUM`.
    - A last term loads `out_sum`, `out_count` and `out_ovf` with the updated values, sets `out_valid`, and returns the FSM to `IDLE` with `acc`, `cnt` and `ovf` cleared.
- **Stall rule**
  - Stage 1 drains unless `s1_last && out_valid && !out_ready`.
  - `in_ready = !s1_valid || drain`.
  - Non-last terms always drain, so a new vector keeps streaming while the previous result is held.
- **Output handshake**
  - `out_valid` stays high, and `out_sum`, `out_count` and `out_ovf` stay stable, until `out_valid && out_ready`.
  - If a new last term drains in the same cycle as that handshake, the output reloads back-to-back and `out_valid` stays high.
- **Arithmetic**
  - All operands and products are unsigned.
  - The 16-bit product is zero-extended to ACC_W bits before the add.
- **Reset values**
  - `in_ready` = 1.
  - `out_valid`, `out_sum`, `out_count`, `out_ovf` = 0.
  - `s1_valid` = 0, FSM = `IDLE`, `acc` = 0, `cnt` = 0.
  - Asserting `rst` mid-vector discards the partial sum and any held or stalled result.

## Timing
- Last term accepted at edge T: `out_valid` is high after edge T+1.
- Minimum latency is two cycles from the input handshake to the output.
- Throughput is one term per cycle while unstalled.
- A vector is one term or more; a single-term vector with `in_last` is legal.
- Under backpressure, at most one last term waits in stage 1. `in_ready` drops only while that term waits.
- `in_*` values are ignored when `in_valid` is low.

## Configuration
- `MAC_SAT_EN` defined:
  - On overflow, `acc` clamps to 2^ACC_W−1 and stays there for the rest of the vector.
  - `out_ovf` = 1.
- `MAC_SAT_EN` undefined:
  - `acc` wraps modulo 2^ACC_W.
  - `out_ovf` is still set, as a sticky flag for the vector.

## Structure
- Package `mac_pkg` holds:
  - the `ACC_W` default constant;
  - the count saturation constant, 255;
  - the FSM state typedef with values `IDLE` and `ACCUM`.
- Sub-module: one instance of `multi_8`, with ports (a, b, o), driven by the stage-1 registers.
- No other hierarchy.

## Test plan
- **Single term:** pair (3,5) with last → `out_sum` = 15, `out_count` = 1, `out_ovf` = 0, `out_valid` after edge T+1.
- **Three-term vector:** pairs (9,9), (17,17), (20,50) with last on the third → `out_sum` = 1370, `out_count` = 3.
- **Backpressure:**
  - Stimulus: after the 1370 vector completes, hold `out_ready` low for 5 cycles while streaming (12,20), (1,255) with last.
  - Result held stable at 1370.
  - `in_ready` low only while the second last term waits.
  - Then 240+255 = 495 after the handshake.
- **Overflow:** 300 terms of (255,255), last on the 300th.
  - Without `MAC_SAT_EN`: `out_sum` = 2,730,284, `out_ovf` = 1, `out_count` = 255.
  - With `MAC_SAT_EN`: `out_sum` = 16,777,215, `out_ovf` = 1, `out_count` = 255.
- **Zero operand:** pairs (0,255), (1,255) with last → `out_sum` = 255, `out_count` = 2.
- **Reset mid-vector:** send (20,50), (9,9), pulse `rst`, then (12,20) with last → `out_sum` = 240, `out_count` = 1. No result is emitted for the aborted vector.
